// File: rtl/ram1p1rwe_clr_pkg.sv
// Shared definitions for the self-clearing single-port RAM.
//   ramclr_state_t : clear-engine state (IDLE = normal access, CLR = sweeping)
//   nlane()        : number of write-enable lanes for a given word/lane width
package ram1p1rwe_clr_pkg;

  typedef enum logic {
    RAMCLR_IDLE = 1'b0,
    RAMCLR_CLR  = 1'b1
  } ramclr_state_t;

  // Top lane may be partial, hence the round-up.
  function automatic int nlane(input int width, input int lanew);
    return (width + lanew - 1) / lanew;
  endfunction

endpackage

// File: rtl/ram1p1rwe_clr_fsm.sv
// Clear engine for ram1p1rwe_clr: state register, sweep counter and busy flag.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (forces a new sweep)
//   clear       : request a full sweep (honoured only while idle)
//   cnt         : entry to be cleared this cycle
//   busy        : sweep in progress (decoded straight from the state flop)
//   sweep_we    : write strobe for RAM[cnt] <= CLRVAL
module ram_clr_fsm
  import ram1p1rwe_clr_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [AW-1:0] cnt,
  output logic          busy,
  output logic          sweep_we
);

  ramclr_state_t state, state_nxt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RAMCLR_CLR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RAMCLR_CLR: begin
        // DEPTH is a power of two, so the increment wraps to 0 on the last entry.
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nxt = RAMCLR_IDLE;
      end
      default: begin
        if (clear) begin
          state_nxt = RAMCLR_CLR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state == RAMCLR_CLR);
    // A reset cycle never writes the array.
    sweep_we = busy && !reset;
  end

endmodule

// File: rtl/ram1p1rwe_clr.sv
// Single-port, read-first synchronous RAM with per-lane write enables and a
// hardware clear engine that sweeps every entry to CLRVAL after reset or on
// a clear request. User accesses are ignored while busy.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   ce, we     : access enable, write enable (qualified by ce)
//   lanewe     : per-lane write enables (qualified by ce & we)
//   addr, din  : word address, write data
//   clear      : pulse to request a full clear
//   dout       : registered read data (holds between ce cycles)
//   busy       : clear engine active
module ram1p1rwe_clr
  import ram1p1rwe_clr_pkg::*;
#(
  parameter  int               DEPTH  = 64,
  parameter  int               WIDTH  = 44,
  parameter  int               LANEW  = WIDTH,
  parameter  logic [WIDTH-1:0] CLRVAL = '0,
  localparam int               NLANE  = nlane(WIDTH, LANEW),
  localparam int               AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             we,
  input  logic [NLANE-1:0] lanewe,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  logic [AW-1:0]    cnt;
  logic             sweep_we;
  logic             user_we;
  logic             rd_en;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NLANE-1:0] wr_lanes;
  logic [WIDTH-1:0] rd_word;

  ram_clr_fsm #(.DEPTH(DEPTH)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .cnt      (cnt),
    .busy     (busy),
    .sweep_we (sweep_we)
  );

  // User traffic is only honoured in IDLE and never in a reset cycle.
  always_comb begin
    rd_en   = ce && !busy && !reset;
    user_we = rd_en && we;
    wr_en   = sweep_we || user_we;
    if (sweep_we) begin
      wr_addr  = cnt;
      wr_data  = CLRVAL;
      wr_lanes = '1;
    end else begin
      wr_addr  = addr;
      wr_data  = din;
      wr_lanes = lanewe;
    end
  end

  // The array is split into one memory per lane so that each lane has its own
  // enable; the top lane is narrowed when WIDTH is not a multiple of LANEW.
  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    localparam int LO = k * LANEW;
    localparam int LW = ((WIDTH - LO) < LANEW) ? (WIDTH - LO) : LANEW;

    logic [LW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && wr_lanes[k]) mem[wr_addr] <= wr_data[LO +: LW];
    end

    assign rd_word[LO +: LW] = mem[addr];
  end

  // rd_word reflects pre-write contents at the edge, giving read-first data.
  always_ff @(posedge clk) begin
    if (reset)      dout <= CLRVAL;
    else if (rd_en) dout <= rd_word;
  end

endmodule

// File: tb/tb_ram1p1rwe_clr.sv
module tb_ram1p1rwe_clr;

  localparam int          DEPTH = 64;
  localparam int          WIDTH = 32;
  localparam int          LANEW = 8;
  localparam logic [31:0] CV    = 32'hA5C3_5A3C;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        we;
  logic [3:0]  lanewe;
  logic [5:0]  addr;
  logic [31:0] din;
  logic        clear;
  logic [31:0] dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram1p1rwe_clr #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .LANEW  (LANEW),
    .CLRVAL (CV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .we     (we),
    .lanewe (lanewe),
    .addr   (addr),
    .din    (din),
    .clear  (clear),
    .dout   (dout),
    .busy   (busy)
  );

  typedef struct {
    logic        ce;
    logic        we;
    logic [3:0]  lanewe;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ce = 1'b0; we = 1'b0; lanewe = 4'h0; addr = '0; din = '0; clear = 1'b0;
  endtask

  // Counts clock periods with busy high, starting from the current period.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic write_word(input logic [5:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; lanewe = 4'hF; addr = a; din = d;
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic read_all(input string name, input logic [31:0] exp);
    for (int i = 0; i < DEPTH; i++) begin
      ce = 1'b1; we = 1'b0; addr = 6'(i);
      step();
      check(name, dout, exp);
    end
    ce = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 6'd5,  32'h0000_0123, CV};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 6'd5,  32'h0000_0456, 32'h0000_0123};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 6'd5,  32'h0000_0000, 32'h0000_0456};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 6'd3,  32'hAABB_CCDD, CV};
    vecs[4]  = '{1'b1, 1'b1, 4'h5, 6'd3,  32'h1122_3344, 32'hAABB_CCDD};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 6'd3,  32'h0000_0000, 32'hAA22_CC44};
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 6'd7,  32'h0000_0055, CV};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 6'd7,  32'h0000_0000, 32'h0000_0055};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 6'd7,  32'h0000_0099, 32'h0000_0055};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 6'd7,  32'h0000_0066, 32'h0000_0055};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 6'd7,  32'h0000_0000, 32'h0000_0055};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 6'd7,  32'h0000_0000, 32'h0000_0055};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 6'd7,  32'h0000_0000, 32'h0000_0066};
    vecs[13] = '{1'b1, 1'b1, 4'h0, 6'd3,  32'h0000_0000, 32'hAA22_CC44};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 6'd3,  32'h0000_0000, 32'hAA22_CC44};
    vecs[15] = '{1'b1, 1'b1, 4'hA, 6'd3,  32'h0F0F_0F0F, 32'hAA22_CC44};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 6'd3,  32'h0000_0000, 32'h0F22_0F44};
    vecs[17] = '{1'b0, 1'b1, 4'hF, 6'd9,  32'h0000_1234, 32'h0F22_0F44};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 6'd9,  32'h0000_0000, CV};

    // Reset held for 3 cycles, then the power-on sweep.
    idle_inputs();
    reset = 1'b1;
    step(); step(); step();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_dout", dout, CV);
    reset = 1'b0;
    count_busy(n);
    check("reset_sweep_len", n, 32'd64);
    read_all("reset_sweep_contents", CV);

    // Directed access vectors: read-first, lanes, dout hold, we with no lanes.
    for (int i = 0; i < 19; i++) begin
      ce = vecs[i].ce; we = vecs[i].we; lanewe = vecs[i].lanewe;
      addr = vecs[i].addr; din = vecs[i].din;
      step();
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
    end
    idle_inputs();

    // Requested clear with user writes during the sweep.
    for (int i = 0; i < DEPTH; i++) write_word(6'(i), 32'h0000_00FF);
    ce = 1'b1; we = 1'b0; addr = 6'd0;
    step();
    check("pre_clear_read", dout, 32'h0000_00FF);
    clear = 1'b1; ce = 1'b0;
    step();
    clear = 1'b0;
    check("clear_busy_rise", {31'b0, busy}, 32'd1);
    ce = 1'b1; we = 1'b1; lanewe = 4'hF; addr = 6'd0; din = 32'h77;
    count_busy(n);
    check("clear_sweep_len", n, 32'd64);
    check("clear_dout_held", dout, 32'h0000_00FF);
    idle_inputs();

    // Back-to-back clear on the cycle busy is first seen low.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("b2b_clear_busy", {31'b0, busy}, 32'd1);
    count_busy(n);
    check("b2b_sweep_len", n, 32'd64);
    read_all("clear_contents", CV);

    // Reset in the middle of a sweep restarts it from entry 0.
    for (int i = 0; i < DEPTH; i++) write_word(6'(i), 32'h1234_5678);
    ce = 1'b1; we = 1'b0; addr = 6'd10;
    step();
    ce = 1'b0;
    check("mid_pre_read", dout, 32'h1234_5678);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_dout_held", dout, 32'h1234_5678);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_dout", dout, CV);
    check("mid_reset_busy", {31'b0, busy}, 32'd1);
    count_busy(n);
    check("mid_reset_sweep_len", n, 32'd64);
    read_all("mid_reset_contents", CV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
